object_table: RTL

- Parametrised successor to the fixed 32-entry object unit.
- Allocates, deletes and tracks object slots for the VPU object store.
- Computes each object's base address and keeps per-object changed (dirty) flags.
- Adds a selectable allocation policy, query of allocated objects, error reporting and occupancy count.
- Sits between the command decoder and the object memory address path.

---
 rtl/object_table.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/object_table.sv
// object_table: slot allocator for the VPU object store.
// Tracks which object slots are allocated, hands out free slots (lowest-free
// or round-robin policy), answers base-address queries and keeps a per-slot
// dirty flag. Multi-cycle commands run through a small IDLE/SRCH/RESP FSM.
module object_table #(
  parameter int                NUM_OBJ    = 32,
  parameter int                OBJ_W      = $clog2(NUM_OBJ),
  parameter int                ADDR_W     = 16,
  parameter int                OBJ_SIZE   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h1000,
  parameter int                ALLOC_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              crt_obj,
  input  logic              del_obj,
  input  logic              del_all,
  input  logic              ref_addr,
  input  logic              changed_in,
  input  logic [OBJ_W-1:0]  obj_num,
  output logic              busy,
  output logic              addr_vld,
  output logic [OBJ_W-1:0]  obj_id,
  output logic [ADDR_W-1:0] obj_addr,
  output logic              obj_dirty,
  output logic              full,
  output logic              err,
  output logic [OBJ_W:0]    obj_cnt
);

  localparam int               SHIFT    = $clog2(OBJ_SIZE);
  localparam logic [OBJ_W:0]   CNT_MAX  = (OBJ_W+1)'(NUM_OBJ);
  localparam logic [OBJ_W-1:0] LAST_IDX = OBJ_W'(NUM_OBJ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRCH = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_OBJ-1:0]  valid_q, valid_d;
  logic [NUM_OBJ-1:0]  dirty_q, dirty_d;
  logic [OBJ_W-1:0]    ptr_q, ptr_d;
  logic [OBJ_W:0]      cnt_q, cnt_d;
  logic [OBJ_W-1:0]    slot_q, slot_d;
  logic                is_ref_q, is_ref_d;
  logic                busy_q;
  logic                addr_vld_q, addr_vld_d;
  logic [OBJ_W-1:0]    obj_id_q, obj_id_d;
  logic [ADDR_W-1:0]   obj_addr_q, obj_addr_d;
  logic                obj_dirty_q, obj_dirty_d;
  logic                full_q;
  logic                err_q, err_d;

  logic [OBJ_W:0]      pick_s;
  logic                multi_s;
  logic                num_valid_s;

  // Bit of v at idx; indices past the last slot read as free.
  function automatic logic slot_valid(input logic [NUM_OBJ-1:0] v,
                                      input logic [OBJ_W-1:0]   idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (idx == OBJ_W'(i)) begin
        r = v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Lowest free slot as {found, index}.
  function automatic logic [OBJ_W:0] find_lowest(input logic [NUM_OBJ-1:0] v);
    logic [OBJ_W:0] r;
    r = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!v[i]) begin
        r = {1'b1, OBJ_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // First free slot at or after p, wrapping past the last slot, as {found, index}.
  function automatic logic [OBJ_W:0] find_rr(input logic [NUM_OBJ-1:0] v,
                                             input logic [OBJ_W-1:0]   p);
    logic [OBJ_W:0] r;
    int             j;
    r = '0;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_OBJ) begin
        j = j - NUM_OBJ;
      end else begin
        j = j;
      end
      if (!v[j]) begin
        r = {1'b1, OBJ_W'(j)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Base address of a slot; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [OBJ_W-1:0] idx);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(idx);
    off = off << SHIFT;
    return BASE_ADDR + off;
  endfunction

  // Free-slot candidate for the allocation policy in use.
  always_comb begin
    if (ALLOC_MODE == 1) begin
      pick_s = find_rr(valid_q, ptr_q);
    end else begin
      pick_s = find_lowest(valid_q);
    end
  end

  // Next-state, table update and response generation.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    is_ref_d    = is_ref_q;
    addr_vld_d  = 1'b0;
    obj_id_d    = obj_id_q;
    obj_addr_d  = obj_addr_q;
    obj_dirty_d = obj_dirty_q;
    err_d       = 1'b0;

    num_valid_s = slot_valid(valid_q, obj_num);
    // Two or more competing commands in the same cycle.
    multi_s = (del_all & del_obj) | (del_all & crt_obj) | (del_all & ref_addr) |
              (del_obj & crt_obj) | (del_obj & ref_addr) | (crt_obj & ref_addr);

    if (del_all) begin
      // Clears everything from any state and drops any pending response.
      valid_d = '0;
      dirty_d = '0;
      cnt_d   = '0;
      ptr_d   = '0;
      state_d = IDLE;
      err_d   = (state_q == IDLE) ? multi_s : 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_d = multi_s;
          if (del_obj) begin
            if (num_valid_s) begin
              valid_d[obj_num] = 1'b0;
              dirty_d[obj_num] = 1'b0;
              cnt_d            = cnt_q - (OBJ_W+1)'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (crt_obj) begin
            if (cnt_q == CNT_MAX) begin
              err_d = 1'b1;
            end else begin
              state_d  = SRCH;
              is_ref_d = 1'b0;
            end
          end else if (ref_addr) begin
            if (num_valid_s) begin
              state_d  = SRCH;
              is_ref_d = 1'b1;
              slot_d   = obj_num;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SRCH: begin
          if (is_ref_q) begin
            state_d = RESP;
          end else if (pick_s[OBJ_W]) begin
            // Claim the chosen slot now so the count is current at response time.
            state_d                   = RESP;
            slot_d                    = pick_s[OBJ_W-1:0];
            valid_d[pick_s[OBJ_W-1:0]] = 1'b1;
            dirty_d[pick_s[OBJ_W-1:0]] = 1'b0;
            cnt_d                     = cnt_q + (OBJ_W+1)'(1);
            ptr_d = (pick_s[OBJ_W-1:0] == LAST_IDX) ? '0 :
                    pick_s[OBJ_W-1:0] + OBJ_W'(1);
          end else begin
            // Table filled up underneath us; report instead of answering.
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        RESP: begin
          state_d     = IDLE;
          addr_vld_d  = 1'b1;
          obj_id_d    = slot_q;
          obj_addr_d  = addr_of(slot_q);
          obj_dirty_d = is_ref_q ? dirty_q[slot_q] : 1'b0;
          if (is_ref_q) begin
            dirty_d[slot_q] = 1'b0;
          end else begin
            dirty_d[slot_q] = dirty_q[slot_q];
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Dirty marking runs beside the FSM: a delete of the same slot this cycle
    // wins (valid_d already cleared), a query-clear of the same slot loses.
    if (changed_in && num_valid_s && slot_valid(valid_d, obj_num)) begin
      dirty_d[obj_num] = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      is_ref_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_vld_q  <= 1'b0;
      obj_id_q    <= '0;
      obj_addr_q  <= '0;
      obj_dirty_q <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      is_ref_q    <= is_ref_d;
      busy_q      <= (state_d != IDLE);
      addr_vld_q  <= addr_vld_d;
      obj_id_q    <= obj_id_d;
      obj_addr_q  <= obj_addr_d;
      obj_dirty_q <= obj_dirty_d;
      full_q      <= (cnt_d == CNT_MAX);
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign addr_vld  = addr_vld_q;
  assign obj_id    = obj_id_q;
  assign obj_addr  = obj_addr_q;
  assign obj_dirty = obj_dirty_q;
  assign full      = full_q;
  assign err       = err_q;
  assign obj_cnt   = cnt_q;

endmodule
